// File: rtl/branch_path_arbiter_if.sv
// Bundle between the two fetch/decode lanes, the branch unit and EX.
//   in_valid/in_data/in_ready   : per-lane issue requests (lane n at [n*DATA_W +: DATA_W])
//   fork_valid/fork_pred/ready  : branch fork request and predicted direction
//   resolve_valid/resolve_taken : branch resolution
//   ex_valid/ex_data/ex_lane/ex_ready : registered issue to EX
//   kill                        : one-cycle flush pulse per lane
//   mode_dual                   : 1 while both lanes are issuing
// master = lanes/branch/EX side, slave = the arbiter.
interface branch_path_arbiter_if #(parameter int DATA_W = 160);
  logic [1:0]          in_valid;
  logic [2*DATA_W-1:0] in_data;
  logic [1:0]          in_ready;
  logic                fork_valid;
  logic                fork_pred;
  logic                fork_ready;
  logic                resolve_valid;
  logic                resolve_taken;
  logic                ex_valid;
  logic [DATA_W-1:0]   ex_data;
  logic                ex_lane;
  logic                ex_ready;
  logic [1:0]          kill;
  logic                mode_dual;

  modport master (
    output in_valid, in_data, fork_valid, fork_pred, resolve_valid, resolve_taken, ex_ready,
    input  in_ready, fork_ready, ex_valid, ex_data, ex_lane, kill, mode_dual
  );

  modport slave (
    input  in_valid, in_data, fork_valid, fork_pred, resolve_valid, resolve_taken, ex_ready,
    output in_ready, fork_ready, ex_valid, ex_data, ex_lane, kill, mode_dual
  );
endinterface

// File: rtl/branch_path_arbiter.sv
// Issue controller sharing one EX datapath between two lanes that run both
// sides of an unresolved branch. SINGLE mode issues only the live lane; DUAL
// mode arbitrates both. On resolution the losing lane is killed and any of its
// ops sitting in the output register are purged.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_path_arbiter_if.slave (requests, fork, resolve, EX, kill)
// Optional feature (macro BRANCH_ARB_PRED_PRIO_EN): under contention the
// predicted lane wins, with one forced grant to the other lane after
// MAX_STREAK consecutive predicted-lane contended grants. Without it, plain
// round-robin.
module branch_path_arbiter #(
  parameter int DATA_W     = 160,
  parameter int MAX_STREAK = 4
) (
  input logic                 clk,
  input logic                 rst,
  branch_path_arbiter_if.slave bus
);
  typedef enum logic {SINGLE = 1'b0, DUAL = 1'b1} state_t;

  state_t state, state_nxt;
  logic live_lane, taken_lane;
  logic [1:0] elig, in_rdy, kill_q;
  logic fork_rdy, dual;
  logic load_en, take, contend, gnt_vld, gnt_lane, prio_lane;
  logic resolve_act, fork_acc, winner, loser;
  logic ex_valid_q, ex_lane_q;
  logic [DATA_W-1:0] ex_data_q;
  logic [1:0][DATA_W-1:0] lane_data;

  assign lane_data   = bus.in_data;
  assign load_en     = bus.ex_ready || !ex_valid_q;
  assign resolve_act = (state == DUAL) && bus.resolve_valid;
  assign fork_acc    = (state == SINGLE) && bus.fork_valid;
  assign winner      = bus.resolve_taken ? taken_lane : ~taken_lane;
  assign loser       = ~winner;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= SINGLE;
    else     state <= state_nxt;
  end

  // FSM: next state. A fork arriving with a resolve in DUAL waits for SINGLE.
  always_comb begin
    state_nxt = state;
    case (state)
      SINGLE: if (bus.fork_valid)    state_nxt = DUAL;
      DUAL:   if (bus.resolve_valid) state_nxt = SINGLE;
      default: state_nxt = SINGLE;
    endcase
  end

  // FSM: outputs / eligibility
  always_comb begin
    elig     = 2'b00;
    fork_rdy = 1'b0;
    dual     = 1'b0;
    case (state)
      SINGLE: begin
        elig[live_lane] = bus.in_valid[live_lane];
        fork_rdy        = 1'b1;
      end
      DUAL: begin
        elig = bus.in_valid;
        dual = 1'b1;
        // the losing lane must not slip an op in during the resolve cycle
        if (bus.resolve_valid) elig[loser] = 1'b0;
      end
      default: ;
    endcase
  end

  assign contend  = &elig;
  assign gnt_vld  = |elig;
  assign gnt_lane = contend ? prio_lane : elig[1];
  assign take     = load_en && gnt_vld;

`ifdef BRANCH_ARB_PRED_PRIO_EN
  logic       pred;
  logic       pred_lane;
  logic [3:0] streak;

  assign pred_lane = pred ? taken_lane : ~taken_lane;
  assign prio_lane = (streak >= 4'(MAX_STREAK)) ? ~pred_lane : pred_lane;

  always_ff @(posedge clk) begin
    if (rst) begin
      pred   <= 1'b0;
      streak <= 4'd0;
    end else if (fork_acc) begin
      pred   <= bus.fork_pred;
      streak <= 4'd0;
    end else if (take && contend) begin
      // a grant to the other lane (the forced one) restarts the run
      streak <= (gnt_lane == pred_lane) ? streak + 4'd1 : 4'd0;
    end
  end
`else
  logic rr_ptr;

  assign prio_lane = rr_ptr;

  // only contended grants advance the pointer
  always_ff @(posedge clk) begin
    if (rst)                  rr_ptr <= 1'b0;
    else if (take && contend) rr_ptr <= ~gnt_lane;
  end
`endif

  genvar n;
  generate
    for (n = 0; n < 2; n++) begin : g_lane
      assign in_rdy[n] = take && (gnt_lane == 1'(n));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      live_lane  <= 1'b0;
      taken_lane <= 1'b0;
      kill_q     <= 2'b00;
    end else begin
      if (resolve_act) live_lane  <= winner;
      if (fork_acc)    taken_lane <= ~live_lane;
      kill_q <= resolve_act ? (loser ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  // Output register. A held loser op is dropped even when EX is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_data_q  <= '0;
      ex_lane_q  <= 1'b0;
    end else if (take) begin
      ex_valid_q <= 1'b1;
      ex_data_q  <= lane_data[gnt_lane];
      ex_lane_q  <= gnt_lane;
    end else if (load_en || (resolve_act && ex_lane_q == loser)) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.fork_ready = fork_rdy;
  assign bus.mode_dual  = dual;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_data    = ex_data_q;
  assign bus.ex_lane    = ex_lane_q;
  assign bus.kill       = kill_q;
endmodule

// File: tb/tb_branch_path_arbiter.sv
module tb_branch_path_arbiter;
  localparam int DW = 32;
  localparam int MS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_path_arbiter_if #(.DATA_W(DW)) bus();
  branch_path_arbiter #(.DATA_W(DW), .MAX_STREAK(MS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // behavioural model state
  bit m_dual, m_live, m_taken, m_pred, m_rr;
  int m_streak;
  bit m_exv, m_exl;
  logic [DW-1:0] m_exd;
  bit [1:0] m_kill;
  bit [1:0] seen_rdy;
  bit seen_fr;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance the
  // model, then check registered outputs at the following negedge.
  task automatic step(input bit r, input bit [1:0] iv, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input bit fv, input bit fp, input bit rv, input bit rt, input bit er);
    bit load, racc, facc, win, gv, contend, gl, pl;
    bit [1:0] el, exp_rdy;
    rst = r; bus.in_valid = iv; bus.in_data = {d1, d0};
    bus.fork_valid = fv; bus.fork_pred = fp; bus.resolve_valid = rv;
    bus.resolve_taken = rt; bus.ex_ready = er;
    #1;
    load = !m_exv || er;
    racc = m_dual && rv;
    facc = !m_dual && fv;
    win  = rt ? m_taken : !m_taken;
    el   = m_dual ? iv : (iv & (2'b01 << m_live));
    if (racc) el[!win] = 1'b0;
    gv = (el != 2'b00);
    contend = (el == 2'b11);
`ifdef BRANCH_ARB_PRED_PRIO_EN
    pl = m_pred ? m_taken : !m_taken;
    gl = contend ? ((m_streak >= MS) ? !pl : pl) : el[1];
`else
    pl = 1'b0;
    gl = contend ? m_rr : el[1];
`endif
    exp_rdy = (load && gv) ? (2'b01 << gl) : 2'b00;
    seen_rdy = bus.in_ready;
    seen_fr  = bus.fork_ready;
    if (!r) begin
      chk("in_ready", bus.in_ready, exp_rdy);
      chk("fork_ready", bus.fork_ready, !m_dual);
      chk("mode_dual_c", bus.mode_dual, m_dual);
    end
    if (r) begin
      m_dual = 0; m_live = 0; m_taken = 0; m_pred = 0; m_rr = 0; m_streak = 0;
      m_exv = 0; m_exl = 0; m_exd = '0; m_kill = 2'b00;
    end else begin
      if (load && gv) begin
        m_exv = 1; m_exl = gl; m_exd = gl ? d1 : d0;
        if (contend) begin
          m_rr = !gl;
          m_streak = (gl == pl) ? m_streak + 1 : 0;
        end
      end else if (load || (racc && m_exl == !win)) m_exv = 0;
      m_kill = racc ? (2'b01 << !win) : 2'b00;
      if (facc) begin m_taken = !m_live; m_pred = fp; m_streak = 0; m_dual = 1; end
      if (racc) begin m_live = win; m_dual = 0; end
    end
    @(posedge clk);
    @(negedge clk);
    chk("ex_valid", bus.ex_valid, m_exv);
    chk("ex_data", bus.ex_data, m_exd);
    chk("ex_lane", bus.ex_lane, m_exl);
    chk("kill", bus.kill, m_kill);
    chk("mode_dual", bus.mode_dual, m_dual);
  endtask

  initial begin
    bit [1:0] ivr;
    @(negedge clk);
    step(1, 2'b11, 1, 2, 0, 0, 0, 0, 1);
    step(1, 2'b11, 1, 2, 0, 0, 0, 0, 1);
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_kill", bus.kill, 0);
    chk("rst_mode", bus.mode_dual, 0);

    // lane 0 streams, lane 1 never accepted
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b11, 32'hA0 + i, 32'hB0 + i, 0, 0, 0, 0, 1);
      chk("s_in_ready", seen_rdy, 2'b01);
      chk("s_lane", bus.ex_lane, 0);
      chk("s_data", bus.ex_data, 32'hA0 + i);
      chk("s_valid", bus.ex_valid, 1);
    end

`ifdef BRANCH_ARB_PRED_PRIO_EN
    begin
      bit [9:0] seq;
      seq = 10'b0111101111; // bit i = lane of grant i (1,1,1,1,0,1,1,1,1,0)
      step(0, 2'b11, 1, 2, 1, 1, 0, 0, 1);
      for (int i = 0; i < 10; i++) begin
        step(0, 2'b11, 32'h100 + i, 32'h200 + i, 0, 0, 0, 0, 1);
        chk("streak_lane", bus.ex_lane, seq[i]);
      end
      step(0, 2'b00, 0, 0, 0, 0, 1, 1, 1);
    end
`else
    // fork then contention: round-robin from rr_ptr=0
    step(0, 2'b11, 32'hC0, 32'hD0, 1, 1, 0, 0, 1);
    chk("fork_mode", bus.mode_dual, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b11, 32'hC1 + i, 32'hD1 + i, 0, 0, 0, 0, 1);
      chk("rr_lane", bus.ex_lane, i[0]);
      chk("dual_fork_ready", seen_fr, 0);
    end
    // hold lane-1 op, resolve not-taken (taken_lane=1): lane 1 purged
    step(0, 2'b10, 32'hE0, 32'hE1, 0, 0, 0, 0, 1);
    chk("pre_lane", bus.ex_lane, 1);
    step(0, 2'b11, 32'hE2, 32'hE3, 0, 0, 1, 0, 0);
    chk("purge_valid", bus.ex_valid, 0);
    chk("purge_kill", bus.kill, 2'b10);
    chk("purge_mode", bus.mode_dual, 0);
    step(0, 2'b11, 32'hE4, 32'hE5, 0, 0, 0, 0, 1);
    chk("post_rdy", seen_rdy, 2'b01);
    chk("post_kill", bus.kill, 2'b00);
`endif

    // same-cycle fork and resolve in DUAL
    step(0, 2'b00, 0, 0, 1, 0, 0, 0, 1);
    step(0, 2'b00, 0, 0, 1, 0, 1, 1, 1);
    chk("fr_blocked", seen_fr, 0);
    chk("fr_kill", bus.kill, 2'b01);
    chk("fr_mode", bus.mode_dual, 0);
    step(0, 2'b00, 0, 0, 1, 0, 0, 0, 1);
    chk("fr_accept", seen_fr, 1);
    chk("fr_mode2", bus.mode_dual, 1);

    // stall with a held op
    step(0, 2'b01, 32'h55, 32'h66, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 2'b11, 32'h70 + i, 32'h80 + i, 0, 0, 0, 0, 0);
      chk("hold_rdy", seen_rdy, 2'b00);
      chk("hold_data", bus.ex_data, 32'h55);
      chk("hold_lane", bus.ex_lane, 0);
    end
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    chk("hold_release", bus.ex_valid, 0);

    // reset mid-operation with a held op in DUAL
    step(0, 2'b10, 32'h90, 32'h91, 0, 0, 0, 0, 1);
    step(1, 2'b11, 32'h92, 32'h93, 0, 0, 1, 0, 0);
    chk("mrst_valid", bus.ex_valid, 0);
    chk("mrst_kill", bus.kill, 0);
    chk("mrst_mode", bus.mode_dual, 0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      ivr = 2'($urandom);
      step(($urandom % 250) == 0, ivr, $urandom, $urandom,
           ($urandom % 6) == 0, 1'($urandom), ($urandom % 7) == 0, 1'($urandom),
           ($urandom % 4) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
